// File: rtl/vga_scanout.sv
// Parametrised VGA timing generator and framebuffer scan-out engine.
// Pixel-enable divider, integer upscaling, colour expansion, vblank buffer swap.
module vga_scanout #(
  parameter int ColorBits = 3,
  parameter int CLK_DIV   = 2,
  parameter int SCALE     = 2,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int XW        = 9,
  parameter int YW        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ColorBits-1:0] readValueMemory,
  input  logic                 swap_req,
  output logic [XW-1:0]        XRead,
  output logic [YW-1:0]        YRead,
  output logic                 buf_sel,
  output logic                 hsync,
  output logic                 vsync,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic                 blank,
  output logic                 clkVGA,
  output logic                 frame_start,
  output logic                 in_vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CW      = ColorBits / 3;

  function automatic logic [7:0] expand(input logic [CW-1:0] f);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) e[7-i] = f[CW-1-(i%CW)];
    return e;
  endfunction

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcnt_q, hcnt_d, hq_q, hq_d;
  logic [VW-1:0] vcnt_q, vcnt_d, vq_q, vq_d;
  logic [SW-1:0] hr_q, hr_d, vr_q, vr_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          act_p_q, act_p_d, hs_p_q, hs_p_d, vs_p_q, vs_p_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          blank_q, blank_d, clkvga_q, clkvga_d;
  logic          fs_q, fs_d, buf_q, buf_d, pend_q, pend_d;
  logic [7:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic          tick, h_in, v_in, svc;

  assign tick = (div_q == '0);
  assign h_in = (hcnt_q < HW'(H_ACTIVE));
  assign v_in = (vcnt_q < VW'(V_ACTIVE));
  assign svc  = tick && (hcnt_q == '0) && (vcnt_q == VW'(V_ACTIVE));

  always_comb begin
    div_d   = (div_q == DW'(CLK_DIV-1)) ? '0 : div_q + DW'(1);
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    hq_d    = hq_q;
    hr_d    = hr_q;
    vq_d    = vq_q;
    vr_d    = vr_q;
    x_d     = x_q;
    y_d     = y_q;
    act_p_d = act_p_q;
    hs_p_d  = hs_p_q;
    vs_p_d  = vs_p_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    blank_d = blank_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (tick) begin
      if (h_in) x_d = XW'(hq_q);
      if (v_in) y_d = YW'(vq_q);
      act_p_d = h_in && v_in;
      hs_p_d  = (hcnt_q >= HW'(HS_BEG)) && (hcnt_q < HW'(HS_END));
      vs_p_d  = (vcnt_q >= VW'(VS_BEG)) && (vcnt_q < VW'(VS_END));
      // Outputs take the previous pixel's pipe so they align with memory data
      hsync_d = hs_p_q ? SYNC_POL : ~SYNC_POL;
      vsync_d = vs_p_q ? SYNC_POL : ~SYNC_POL;
      blank_d = act_p_q;
      red_d   = act_p_q ? expand(readValueMemory[3*CW-1 -: CW]) : 8'h00;
      green_d = act_p_q ? expand(readValueMemory[2*CW-1 -: CW]) : 8'h00;
      blue_d  = act_p_q ? expand(readValueMemory[CW-1:0]) : 8'h00;
      if (hcnt_q == HW'(H_TOTAL-1)) begin
        hcnt_d = '0;
        hq_d   = '0;
        hr_d   = '0;
        if (vcnt_q == VW'(V_TOTAL-1)) begin
          vcnt_d = '0;
          vq_d   = '0;
          vr_d   = '0;
        end else begin
          vcnt_d = vcnt_q + VW'(1);
          if (vr_q == SW'(SCALE-1)) begin
            vr_d = '0;
            vq_d = vq_q + VW'(1);
          end else begin
            vr_d = vr_q + SW'(1);
          end
        end
      end else begin
        hcnt_d = hcnt_q + HW'(1);
        if (hr_q == SW'(SCALE-1)) begin
          hr_d = '0;
          hq_d = hq_q + HW'(1);
        end else begin
          hr_d = hr_q + SW'(1);
        end
      end
    end
  end

  always_comb begin
    fs_d     = tick && (hcnt_q == '0) && (vcnt_q == '0);
    clkvga_d = (int'(div_d) < CLK_DIV/2);
    buf_d    = buf_q;
    pend_d   = pend_q | swap_req;
    // A request arriving on the service clk is folded into this swap
    if (svc) begin
      if (pend_q || swap_req) buf_d = ~buf_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hq_q     <= '0;
      hr_q     <= '0;
      vq_q     <= '0;
      vr_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      act_p_q  <= 1'b0;
      hs_p_q   <= 1'b0;
      vs_p_q   <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      blank_q  <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      fs_q     <= 1'b0;
      clkvga_q <= 1'b0;
      buf_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      hq_q     <= hq_d;
      hr_q     <= hr_d;
      vq_q     <= vq_d;
      vr_q     <= vr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      act_p_q  <= act_p_d;
      hs_p_q   <= hs_p_d;
      vs_p_q   <= vs_p_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      blank_q  <= blank_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      fs_q     <= fs_d;
      clkvga_q <= clkvga_d;
      buf_q    <= buf_d;
      pend_q   <= pend_d;
    end
  end

  assign XRead       = x_q;
  assign YRead       = y_q;
  assign buf_sel     = buf_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign blank       = blank_q;
  assign clkVGA      = clkvga_q;
  assign frame_start = fs_q;
  assign in_vblank   = (vcnt_q >= VW'(V_ACTIVE));

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two reduced-geometry instances checked every clk
// against a pixel-index reference model through per-instance scoreboards.
module tb_vga_scanout;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 8, VFP = 1, VSY = 2, VBP = 2;
  localparam int DIV = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT * DIV;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic bs, hs, vs, bl;
    logic [7:0] r, g, b;
    logic fs, ivb, cv;
  } obs_t;

  logic clk = 1'b0;
  logic reset, swap_req;
  logic [2:0] rd_a;
  logic [5:0] rd_b;
  logic [8:0] xa;
  logic [7:0] ya;
  logic [3:0] xb;
  logic [2:0] yb;
  logic bsa, hsa, vsa, bla, cva, fsa, iva;
  logic bsb, hsb, vsb, blb, cvb, fsb, ivb;
  logic [7:0] ra, gra, ba, rb, grb, bb;
  int seed_a, seed_b;
  int checks = 0, errors = 0;
  obs_t qa[$], qb[$];

  always #5 clk = ~clk;

  vga_scanout #(
    .ColorBits(3), .CLK_DIV(DIV), .SCALE(2),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1'b0), .XW(9), .YW(8)
  ) dut_a (
    .clk(clk), .reset(reset), .readValueMemory(rd_a),
    .swap_req(swap_req), .XRead(xa), .YRead(ya), .buf_sel(bsa),
    .hsync(hsa), .vsync(vsa), .red(ra), .green(gra), .blue(ba),
    .blank(bla), .clkVGA(cva), .frame_start(fsa), .in_vblank(iva)
  );

  vga_scanout #(
    .ColorBits(6), .CLK_DIV(DIV), .SCALE(1),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1'b1), .XW(4), .YW(3)
  ) dut_b (
    .clk(clk), .reset(reset), .readValueMemory(rd_b),
    .swap_req(swap_req), .XRead(xb), .YRead(yb), .buf_sel(bsb),
    .hsync(hsb), .vsync(vsb), .red(rb), .green(grb), .blue(bb),
    .blank(blb), .clkVGA(cvb), .frame_start(fsb), .in_vblank(ivb)
  );

  function automatic int code(int seed, bit bs, int x, int y, int cb);
    return (x * 5 + y * 11 + int'(bs) * 3 + seed) % (1 << cb);
  endfunction

  function automatic logic [7:0] rep(int f, int cw);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) e[7-i] = f[cw-1-(i%cw)];
    return e;
  endfunction

  function automatic obs_t reset_obs(bit pol);
    obs_t e;
    e = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    return e;
  endfunction

  function automatic obs_t expect_at(int k, int ph, int n, int s, int cb,
                                     bit pol, int xw, int yw, int seed,
                                     bit bs);
    obs_t e;
    int h, v, hp, vp, c, cw;
    e = reset_obs(pol);
    h = k % HT;
    v = (k / HT) % VT;
    e.x = 9'((((h < HA) ? h : HA - 1) / s) % (1 << xw));
    e.y = 8'((((v < VA) ? v : VA - 1) / s) % (1 << yw));
    e.bs = bs;
    if (k > 0) begin
      hp = (k - 1) % HT;
      vp = ((k - 1) / HT) % VT;
      if (hp >= HA + HFP && hp < HA + HFP + HSY) e.hs = pol;
      if (vp >= VA + VFP && vp < VA + VFP + VSY) e.vs = pol;
      if (hp < HA && vp < VA) begin
        cw = cb / 3;
        c = code(seed, bs, (hp / s) % (1 << xw), (vp / s) % (1 << yw), cb);
        e.bl = 1'b1;
        e.r = rep((c >> (2 * cw)) % (1 << cw), cw);
        e.g = rep((c >> cw) % (1 << cw), cw);
        e.b = rep(c % (1 << cw), cw);
      end
    end
    e.fs = (ph == 0) && (h == 0) && (v == 0);
    e.ivb = ((((k + 1) / HT) % VT) >= VA);
    e.cv = ((n % DIV) < DIV / 2);
    return e;
  endfunction

  always @(posedge clk) begin
    rd_a <= 3'(code(seed_a, bsa, int'(xa), int'(ya), 3));
    rd_b <= 6'(code(seed_b, bsb, int'(xb), int'(yb), 6));
  end

  // Reference model: everything follows from the clk count since reset
  initial begin
    int n, ph, k;
    bit bs, pend;
    n = 0;
    bs = 1'b0;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        n = 0;
        bs = 1'b0;
        pend = 1'b0;
        qa.push_back(reset_obs(1'b0));
        qb.push_back(reset_obs(1'b1));
      end else begin
        n++;
        ph = (n - 1) % DIV;
        k = (n - 1) / DIV;
        if (ph == 0 && k % HT == 0 && (k / HT) % VT == VA) begin
          if (pend || swap_req) bs = ~bs;
          pend = 1'b0;
        end else if (swap_req) begin
          pend = 1'b1;
        end
        qa.push_back(expect_at(k, ph, n, 2, 3, 1'b0, 9, 8, seed_a, bs));
        qb.push_back(expect_at(k, ph, n, 1, 6, 1'b1, 4, 3, seed_b, bs));
      end
    end
  end

  task automatic chk(input string nm, input obs_t got, input obs_t exp,
                     input int cyc);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s cyc %0d got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  initial begin
    obs_t e, g;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        g = {xa, ya, bsa, hsa, vsa, bla, ra, gra, ba, fsa, iva, cva};
        chk("dut_a", g, e, cyc);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        g = {5'b0, xb, 5'b0, yb, bsb, hsb, vsb, blb, rb, grb, bb,
             fsb, ivb, cvb};
        chk("dut_b", g, e, cyc);
      end
    end
  end

  initial begin
    seed_a = $urandom_range(0, 1000);
    seed_b = $urandom_range(0, 1000);
    reset = 1'b1;
    swap_req = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 2132; c++) begin
      reset = 1'b0;
      swap_req = (c == 100 || c == 200 || c == 1009 ||
                  c == 1298 || c == 1633);
      @(negedge clk);
    end
    reset = 1'b1;
    swap_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 3 * FT + 10; c++) begin
      swap_req = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    swap_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
